// File: rtl/sort_sequencer_if.sv
// rtl/sort_sequencer_if.sv - producer/consumer stream bundle for the sort sequencer
interface sort_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/sort_sequencer.sv
// rtl/sort_sequencer.sv - bubble sort engine sharing one compare/swap unit over a frame buffer
module sort_sequencer #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_sequencer_if.slave   bus
);
    localparam int IDX_W = $clog2(DIM);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] LAST_J    = IDX_W'(DIM - 2);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DIM - 2);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_buf [DIM];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_pass;
    logic             r_swapped;

    logic [IDX_W-1:0] w_j_next;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_swap;
    logic             w_pass_end;
    logic             w_sort_done;
    logic             w_in_fire;
    logic             w_out_fire;

    // Shared compare unit: adjacent pair at r_j, strict compare keeps equal elements in order
    assign w_j_next    = r_j + ONE;
    assign w_a         = r_buf[r_j];
    assign w_b         = r_buf[w_j_next];
    assign w_swap      = (w_a > w_b);
    assign w_pass_end  = (r_j == LAST_J);
    assign w_sort_done = w_pass_end && (!(r_swapped || w_swap) || (r_pass == LAST_PASS));
    assign w_in_fire   = (r_state == S_LOAD) && bus.in_valid;
    assign w_out_fire  = (r_state == S_DRAIN) && bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: full frame -> sort, clean or exhausted pass -> drain, last handshake -> load
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_wr_idx == LAST_IDX)) w_next = S_SORT;
            S_SORT:  if (w_sort_done) w_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && (r_rd_idx == LAST_IDX)) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    // Outputs decode registered state only, so no path from in_valid/out_ready
    always_comb begin
        bus.in_ready  = (r_state == S_LOAD);
        bus.out_valid = (r_state == S_DRAIN);
        bus.out_last  = (r_state == S_DRAIN) && (r_rd_idx == LAST_IDX);
        bus.busy      = (r_state != S_LOAD);
        bus.out_data  = r_buf[r_rd_idx];
    end

    // Datapath: buffer fill, compare/swap sequencing and drain pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) r_buf[i] <= '0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_wr_idx] <= bus.in_data;
                        r_wr_idx        <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + ONE;
                    end
                end
                S_SORT: begin
                    if (w_swap) begin
                        r_buf[r_j]      <= w_b;
                        r_buf[w_j_next] <= w_a;
                    end
                    if (w_pass_end) begin
                        r_j       <= '0;
                        r_swapped <= 1'b0;
                        r_pass    <= w_sort_done ? '0 : r_pass + ONE;
                    end else begin
                        r_j       <= w_j_next;
                        r_swapped <= r_swapped | w_swap;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb/tb_sort_sequencer.sv - randomized self-checking bench for sort_sequencer
module tb_sort_sequencer;
    localparam int DIM   = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_sequencer_if #(.WIDTH(WIDTH)) bus();

    sort_sequencer #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Passes = largest count of strictly greater predecessors + 1 clean pass, capped at DIM-1
    function automatic int ref_passes(input int v[DIM]);
        int worst = 0;
        for (int i = 0; i < DIM; i++) begin
            int cnt = 0;
            for (int k = 0; k < i; k++) if (v[k] > v[i]) cnt++;
            if (cnt > worst) worst = cnt;
        end
        return (worst + 1 > DIM - 1) ? DIM - 1 : worst + 1;
    endfunction

    function automatic void ref_sort(input int v[DIM], output int s[DIM]);
        int q[$];
        for (int i = 0; i < DIM; i++) q.push_back(v[i]);
        q.sort();
        for (int i = 0; i < DIM; i++) s[i] = q[i];
    endfunction

    task automatic load_frame(input int v[DIM]);
        for (int i = 0; i < DIM; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'(v[i]);
            check("in_ready_load", int'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // mode 0: out_ready always high, 1: pattern 1,0,0,1,..., 2: random
    task automatic run_frame(input int v[DIM], input int mode, input bit noise);
        int  exp_s[DIM];
        int  p;
        int  n;
        int  k;
        int  cyc;
        ref_sort(v, exp_s);
        p = ref_passes(v);
        load_frame(v);
        n = 1;
        check("busy_sort", int'(bus.busy), 1);
        check("in_ready_sort", int'(bus.in_ready), 0);
        while (!bus.out_valid && n < 200) begin
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.in_data  = WIDTH'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            n++;
        end
        check("sort_latency", n, p * (DIM - 1) + 1);
        k = 0;
        cyc = 0;
        while (k < DIM && cyc < 60) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.in_data  = WIDTH'($urandom_range(0, 255));
            end
            check("out_valid", int'(bus.out_valid), 1);
            check("out_data", int'(bus.out_data), exp_s[k]);
            check("out_last", int'(bus.out_last), (k == DIM - 1) ? 1 : 0);
            check("in_ready_drain", int'(bus.in_ready), 0);
            @(posedge clk); #1;
            if (bus.out_ready) k++;
            cyc++;
        end
        check("drain_count", k, DIM);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("in_ready_after", int'(bus.in_ready), 1);
        check("out_valid_after", int'(bus.out_valid), 0);
        check("busy_after", int'(bus.busy), 0);
    endtask

    initial begin
        int f[DIM];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        check("post_rst_busy", int'(bus.busy), 0);

        f = '{1, 2, 3, 4};         run_frame(f, 0, 1'b0);
        f = '{200, 150, 100, 50};  run_frame(f, 0, 1'b0);
        f = '{255, 0, 255, 0};     run_frame(f, 0, 1'b0);
        f = '{9, 3, 7, 1};         run_frame(f, 1, 1'b1);

        f = '{4, 3, 2, 1};
        load_frame(f);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midsort_rst_in_ready", int'(bus.in_ready), 1);
        check("midsort_rst_busy", int'(bus.busy), 0);
        check("midsort_rst_out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        f = '{8, 6, 7, 5};         run_frame(f, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            bit narrow;
            narrow = 1'($urandom_range(0, 1));
            for (int i = 0; i < DIM; i++)
                f[i] = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            run_frame(f, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
